// File: rtl/bit_serial_subtractor.sv
// Bit-serial a - b, LSB first, using one full-subtractor cell and a registered borrow.
// Define SIGNED_OVF_EN to add the two's-complement overflow output.
module bit_serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
`ifdef SIGNED_OVF_EN
  ,
  output logic             overflow
`endif
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] areg;
  logic [WIDTH-1:0] breg;
  logic             bin;
  logic             a0;
  logic             b0;
  logic             d;
  logic             bout;
`ifdef SIGNED_OVF_EN
  logic             amsb;
  logic             bmsb;
`endif

  always_comb begin
    a0   = areg[0];
    b0   = breg[0];
    d    = a0 ^ b0 ^ bin;
    bout = (~a0 & b0) | (~(a0 ^ b0) & bin);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      areg       <= '0;
      breg       <= '0;
      bin        <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
`ifdef SIGNED_OVF_EN
      amsb       <= 1'b0;
      bmsb       <= 1'b0;
      overflow   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            areg  <= a;
            breg  <= b;
            bin   <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= SHIFT;
`ifdef SIGNED_OVF_EN
            amsb  <= a[WIDTH-1];
            bmsb  <= b[WIDTH-1];
`endif
          end
        end
        SHIFT: begin
          diff <= {d, diff[WIDTH-1:1]};
          areg <= areg >> 1;
          breg <= breg >> 1;
          bin  <= bout;
          cnt  <= cnt + CW'(1);
          // Last bit: the final d is the result MSB, so overflow is formed from it directly.
          if (cnt == CW'(WIDTH - 1)) begin
            state      <= DONE;
            busy       <= 1'b0;
            done       <= 1'b1;
            borrow_out <= bout;
`ifdef SIGNED_OVF_EN
            overflow   <= (amsb != bmsb) && (d != amsb);
`endif
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bit_serial_subtractor.sv
// Directed bench for bit_serial_subtractor (WIDTH=8) with an expected-result queue.
// Overflow checks are compiled in when SIGNED_OVF_EN is defined.
module tb_bit_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow_out;
`ifdef SIGNED_OVF_EN
  logic         overflow;
`endif

  typedef struct {
    logic [W-1:0] d;
    logic         bo;
    logic         ov;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  bit_serial_subtractor #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .diff       (diff),
    .borrow_out (borrow_out)
`ifdef SIGNED_OVF_EN
    ,
    .overflow   (overflow)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_diff"}, 32'(diff), 32'd0);
    chk({tag, "_bo"},   32'(borrow_out), 32'd0);
`ifdef SIGNED_OVF_EN
    chk({tag, "_ov"},   32'(overflow), 32'd0);
`endif
  endtask

  // Drives one operation; mid>0 pulses junk start that many negedges into SHIFT,
  // dpulse raises junk start while done is high.
  task automatic op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                    input int mid, input bit dpulse);
    exp_t e;
    int   edges;
    int   busy_cnt;
    int   done_cnt;
    logic [W-1:0] dm;
    @(negedge clk);
    start = 1'b1;
    a     = av;
    b     = bv;
    dm    = av - bv;
    e.d   = dm;
    e.bo  = (av < bv);
    e.ov  = (av[W-1] != bv[W-1]) && (dm[W-1] != av[W-1]);
    q.push_back(e);
    @(negedge clk);
    start    = 1'b0;
    a        = 8'hAA;
    b        = 8'h55;
    chk({tag, "_busy_after_accept"}, 32'(busy), 32'd1);
    edges    = 0;
    busy_cnt = busy ? 1 : 0;
    done_cnt = 0;
    while (!done && edges < 20) begin
      @(negedge clk);
      edges++;
      start = 1'b0;
      if (edges == mid) start = 1'b1;
      if (busy) busy_cnt++;
    end
    if (done) done_cnt++;
    chk({tag, "_latency"}, 32'(edges), 32'd8);
    chk({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd8);
    chk({tag, "_queue_nonempty"}, 32'(q.size() > 0), 32'd1);
    if (q.size() > 0) e = q.pop_front();
    chk({tag, "_diff"}, 32'(diff), 32'(e.d));
    chk({tag, "_borrow"}, 32'(borrow_out), 32'(e.bo));
`ifdef SIGNED_OVF_EN
    chk({tag, "_overflow"}, 32'(overflow), 32'(e.ov));
`endif
    start = dpulse;
    @(negedge clk);
    start = 1'b0;
    if (done) done_cnt++;
    chk({tag, "_done_count"}, 32'(done_cnt), 32'd1);
    chk({tag, "_busy_after_done"}, 32'(busy), 32'd0);
    chk({tag, "_diff_hold"}, 32'(diff), 32'(e.d));
  endtask

  initial begin
    int dcnt;
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    #1;
    chk_zero_outputs("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    op("t1", 8'h05, 8'h03, 0, 1'b0);
    op("t2", 8'h03, 8'h05, 0, 1'b0);
    op("t3", 8'h80, 8'h01, 0, 1'b0);
    op("t4a", 8'h00, 8'h00, 0, 1'b0);
    op("t4b", 8'hFF, 8'hFF, 0, 1'b0);
    op("t5", 8'h10, 8'h01, 3, 1'b1);
    op("t5_next", 8'h7F, 8'h80, 0, 1'b0);

    // Reset four edges into SHIFT aborts the operation.
    @(negedge clk);
    start = 1'b1;
    a     = 8'hF0;
    b     = 8'h0F;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    chk_zero_outputs("t6_abort");
    @(negedge clk);
    rst  = 1'b0;
    dcnt = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    chk("t6_no_done", 32'(dcnt), 32'd0);
    chk("t6_idle_busy", 32'(busy), 32'd0);
    op("t6_after", 8'h3C, 8'h5A, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
